// File: rtl/prbs_sym_checker.sv
// Self-synchronising 22-bit PRBS checker for 2-bit slicer decisions; counts symbol/bit errors per window.
// Optional macro PRBS_SYM_CHECKER_GRAY_EN: treat slice as Gray-coded (decode before use, count bits in Gray).
module prbs_sym_checker #(
    parameter int unsigned LFSR_LEN    = 22,
    parameter int unsigned TAP_HI      = 21,
    parameter int unsigned TAP_LO      = 20,
    parameter int unsigned VERIFY_LEN  = 32,
    parameter int unsigned LOSS_BLK    = 64,
    parameter int unsigned LOSS_THRESH = 8,
    parameter int unsigned WIN_LEN     = 65536,
    parameter int unsigned CNT_W       = 18
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             sym_clk_en,
    input  logic             clear,
    input  logic [1:0]       slice,
    output logic             locked,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] sym_err_out,
    output logic [CNT_W-1:0] bit_err_out,
    output logic             window_done,
    output logic [7:0]       resync_cnt
);

    localparam int unsigned FILL_W = $clog2(LFSR_LEN + 1);
    localparam int unsigned VER_W  = $clog2(VERIFY_LEN + 1);
    localparam int unsigned BLK_W  = $clog2(LOSS_BLK);
    localparam int unsigned BERR_W = $clog2(LOSS_THRESH + 1);
    localparam int unsigned WIN_W  = $clog2(WIN_LEN);

    localparam logic [FILL_W-1:0] FILL_LAST   = FILL_W'(LFSR_LEN - 1);
    localparam logic [VER_W-1:0]  VER_LAST    = VER_W'(VERIFY_LEN - 1);
    localparam logic [BLK_W-1:0]  BLK_LAST    = BLK_W'(LOSS_BLK - 1);
    localparam logic [BERR_W-1:0] BERR_THRESH = BERR_W'(LOSS_THRESH);
    localparam logic [WIN_W-1:0]  WIN_LAST    = WIN_W'(WIN_LEN - 1);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCK   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [LFSR_LEN-1:0] r_q, r_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [VER_W-1:0]    ver_q, ver_d;
    logic [WIN_W-1:0]    win_q, win_d;
    logic [BLK_W-1:0]    blk_q, blk_d;
    logic [BERR_W-1:0]   berr_q, berr_d;
    logic [CNT_W-1:0]    sym_acc_q, sym_acc_d;
    logic [CNT_W-1:0]    bit_acc_q, bit_acc_d;
    logic [CNT_W-1:0]    sym_out_q, sym_out_d;
    logic [CNT_W-1:0]    bit_out_q, bit_out_d;
    logic                done_q, done_d;
    logic                locked_q, locked_d;
    logic [7:0]          resync_q, resync_d;

    logic [1:0]          sl_bin_c;
    logic [LFSR_LEN-1:0] pred_state_c;
    logic [1:0]          diff_c;
    logic                sym_err_c;
    logic [1:0]          bit_errs_c;
    logic [CNT_W-1:0]    sym_next_c;
    logic [CNT_W-1:0]    bit_next_c;
    logic [BERR_W-1:0]   berr_next_c;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W + 1)'(b);
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    // Prediction, compare and per-symbol error contributions
    always_comb begin
`ifdef PRBS_SYM_CHECKER_GRAY_EN
        sl_bin_c = {slice[1], slice[1] ^ slice[0]};
`else
        sl_bin_c = slice;
`endif
        pred_state_c = {r_q[LFSR_LEN-2:0], r_q[TAP_HI] ^ r_q[TAP_LO]};
        sym_err_c    = (pred_state_c[1:0] != sl_bin_c);
`ifdef PRBS_SYM_CHECKER_GRAY_EN
        diff_c = {pred_state_c[1], pred_state_c[1] ^ pred_state_c[0]} ^ slice;
`else
        diff_c = pred_state_c[1:0] ^ slice;
`endif
        bit_errs_c  = 2'(diff_c[0]) + 2'(diff_c[1]);
        sym_next_c  = sat_add(sym_acc_q, 2'(sym_err_c));
        bit_next_c  = sat_add(bit_acc_q, bit_errs_c);
        berr_next_c = berr_q + BERR_W'(sym_err_c);
    end

    // Next-state and register updates
    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        fill_d    = fill_q;
        ver_d     = ver_q;
        win_d     = win_q;
        blk_d     = blk_q;
        berr_d    = berr_q;
        sym_acc_d = sym_acc_q;
        bit_acc_d = bit_acc_q;
        sym_out_d = sym_out_q;
        bit_out_d = bit_out_q;
        resync_d  = resync_q;
        done_d    = 1'b0;

        if (clear) begin
            state_d   = ST_HUNT;
            r_d       = '0;
            fill_d    = '0;
            ver_d     = '0;
            win_d     = '0;
            blk_d     = '0;
            berr_d    = '0;
            sym_acc_d = '0;
            bit_acc_d = '0;
            sym_out_d = '0;
            bit_out_d = '0;
            resync_d  = '0;
        end else if (sym_clk_en) begin
            case (state_q)
                ST_HUNT: begin
                    r_d = {r_q[LFSR_LEN-2:0], sl_bin_c[0]};
                    // An all-zero fill is the lock-up state: count from the first non-zero bit
                    if (r_d == '0) begin
                        fill_d = '0;
                    end else if (fill_q == FILL_LAST) begin
                        fill_d  = '0;
                        ver_d   = '0;
                        state_d = ST_VERIFY;
                    end else begin
                        fill_d = fill_q + FILL_W'(1);
                    end
                end
                ST_VERIFY: begin
                    r_d = pred_state_c;
                    if (sym_err_c) begin
                        state_d = ST_HUNT;
                        fill_d  = '0;
                    end else if (ver_q == VER_LAST) begin
                        state_d   = ST_LOCK;
                        win_d     = '0;
                        blk_d     = '0;
                        berr_d    = '0;
                        sym_acc_d = '0;
                        bit_acc_d = '0;
                    end else begin
                        ver_d = ver_q + VER_W'(1);
                    end
                end
                ST_LOCK: begin
                    r_d = pred_state_c;
                    if (berr_next_c >= BERR_THRESH) begin
                        // Loss of lock beats a coincident window end
                        state_d = ST_HUNT;
                        fill_d  = '0;
                        ver_d   = '0;
                        if (resync_q != 8'hFF) begin
                            resync_d = resync_q + 8'd1;
                        end
                    end else begin
                        if (win_q == WIN_LAST) begin
                            sym_out_d = sym_next_c;
                            bit_out_d = bit_next_c;
                            done_d    = 1'b1;
                            sym_acc_d = '0;
                            bit_acc_d = '0;
                            win_d     = '0;
                        end else begin
                            sym_acc_d = sym_next_c;
                            bit_acc_d = bit_next_c;
                            win_d     = win_q + WIN_W'(1);
                        end
                        if (blk_q == BLK_LAST) begin
                            blk_d  = '0;
                            berr_d = '0;
                        end else begin
                            blk_d  = blk_q + BLK_W'(1);
                            berr_d = berr_next_c;
                        end
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                    fill_d  = '0;
                end
            endcase
        end

        locked_d = (state_d == ST_LOCK);
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_HUNT;
            r_q       <= '0;
            fill_q    <= '0;
            ver_q     <= '0;
            win_q     <= '0;
            blk_q     <= '0;
            berr_q    <= '0;
            sym_acc_q <= '0;
            bit_acc_q <= '0;
            sym_out_q <= '0;
            bit_out_q <= '0;
            done_q    <= 1'b0;
            locked_q  <= 1'b0;
            resync_q  <= '0;
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            fill_q    <= fill_d;
            ver_q     <= ver_d;
            win_q     <= win_d;
            blk_q     <= blk_d;
            berr_q    <= berr_d;
            sym_acc_q <= sym_acc_d;
            bit_acc_q <= bit_acc_d;
            sym_out_q <= sym_out_d;
            bit_out_q <= bit_out_d;
            done_q    <= done_d;
            locked_q  <= locked_d;
            resync_q  <= resync_d;
        end
    end

    assign locked      = locked_q;
    assign state       = state_q;
    assign sym_err_out = sym_out_q;
    assign bit_err_out = bit_out_q;
    assign window_done = done_q;
    assign resync_cnt  = resync_q;

endmodule

// File: tb/tb_prbs_sym_checker.sv
// Directed bench for prbs_sym_checker (binary slice build); window shortened to 512 symbols.
module tb_prbs_sym_checker;

    localparam int unsigned CNT_W = 18;

    logic             sys_clk;
    logic             reset;
    logic             sym_clk_en;
    logic             clear;
    logic [1:0]       slice;
    logic             locked;
    logic [1:0]       state;
    logic [CNT_W-1:0] sym_err_out;
    logic [CNT_W-1:0] bit_err_out;
    logic             window_done;
    logic [7:0]       resync_cnt;

    int          n_tests;
    int          n_fail;
    logic [21:0] tx_s;
    logic        seen;

    prbs_sym_checker #(.WIN_LEN(512), .CNT_W(CNT_W)) dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .sym_clk_en (sym_clk_en),
        .clear      (clear),
        .slice      (slice),
        .locked     (locked),
        .state      (state),
        .sym_err_out(sym_err_out),
        .bit_err_out(bit_err_out),
        .window_done(window_done),
        .resync_cnt (resync_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    function automatic logic [21:0] lfsr_next(input logic [21:0] s);
        return {s[20:0], s[21] ^ s[20]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic send(input logic [1:0] sl);
        slice      = sl;
        sym_clk_en = 1'b1;
        @(posedge sys_clk);
        #1;
        sym_clk_en = 1'b0;
    endtask

    task automatic send_tx(input logic [1:0] mask);
        send(tx_s[1:0] ^ mask);
        tx_s = lfsr_next(tx_s);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic relock(input string tag);
        repeat (53) send_tx(2'b00);
        check({tag, "_not_yet"}, 32'(locked), 32'd0);
        send_tx(2'b00);
        check({tag, "_locked"}, 32'(locked), 32'd1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_state"}, 32'(state), 32'd0);
        check({tag, "_locked"}, 32'(locked), 32'd0);
        check({tag, "_sym"}, 32'(sym_err_out), 32'd0);
        check({tag, "_bit"}, 32'(bit_err_out), 32'd0);
        check({tag, "_wd"}, 32'(window_done), 32'd0);
        check({tag, "_resync"}, 32'(resync_cnt), 32'd0);
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        reset      = 1'b0;
        clear      = 1'b0;
        sym_clk_en = 1'b0;
        slice      = 2'b00;
        tx_s       = 22'h3FFFFF;
        idle(3);
        check_zero("reset");

        // Clean stream: lock exactly 54 strobes after the first
        reset = 1'b1;
        idle(1);
        repeat (53) send_tx(2'b00);
        check("verify_at_53", 32'(state), 32'd1);
        check("unlocked_at_53", 32'(locked), 32'd0);
        send_tx(2'b00);
        check("locked_at_54", 32'(locked), 32'd1);
        check("state_lock", 32'(state), 32'd2);

        // Window A: clean, with a strobe gap before the last symbol
        repeat (511) send_tx(2'b00);
        idle(3);
        check("a_no_done_early", 32'(window_done), 32'd0);
        send_tx(2'b00);
        check("a_done", 32'(window_done), 32'd1);
        check("a_sym", 32'(sym_err_out), 32'd0);
        check("a_bit", 32'(bit_err_out), 32'd0);
        idle(1);
        check("a_done_one_cycle", 32'(window_done), 32'd0);

        // Window B: 5 inverted symbols and 3 bit0 flips -> 8 / 13
        for (int i = 0; i < 512; i++) begin
            logic [1:0] m;
            m = 2'b00;
            if (i == 10 || i == 100 || i == 200 || i == 300 || i == 400) m = 2'b11;
            if (i == 50 || i == 150 || i == 250) m = 2'b01;
            if (i == 256) idle(5);
            if (i == 511) check("b_held_prev", 32'(sym_err_out), 32'd0);
            send_tx(m);
        end
        check("b_done", 32'(window_done), 32'd1);
        check("b_sym", 32'(sym_err_out), 32'd8);
        check("b_bit", 32'(bit_err_out), 32'd13);
        check("b_locked", 32'(locked), 32'd1);

        // Window C: 8 errors inside block 0 -> loss, results held
        repeat (20) send_tx(2'b00);
        repeat (7) send_tx(2'b11);
        check("c_still_lock_7", 32'(state), 32'd2);
        send_tx(2'b11);
        check("c_hunt_8", 32'(state), 32'd0);
        check("c_unlocked", 32'(locked), 32'd0);
        check("c_resync", 32'(resync_cnt), 32'd1);
        check("c_no_done", 32'(window_done), 32'd0);
        check("c_sym_held", 32'(sym_err_out), 32'd8);
        check("c_bit_held", 32'(bit_err_out), 32'd13);
        relock("c_relock");

        // Window D: 8th error lands on the window's last strobe -> loss wins
        repeat (504) send_tx(2'b00);
        repeat (8) send_tx(2'b01);
        check("d_hunt", 32'(state), 32'd0);
        check("d_no_done", 32'(window_done), 32'd0);
        check("d_sym_held", 32'(sym_err_out), 32'd8);
        check("d_resync", 32'(resync_cnt), 32'd2);
        idle(1);
        check("d_no_late_done", 32'(window_done), 32'd0);
        relock("d_relock");

        // Window E: 7 errors either side of a block boundary, no loss
        for (int i = 0; i < 512; i++) begin
            logic [1:0] m;
            m = 2'b00;
            if (i >= 57 && i <= 63) m = 2'b01;
            if (i >= 64 && i <= 70) m = 2'b10;
            send_tx(m);
        end
        check("e_done", 32'(window_done), 32'd1);
        check("e_sym", 32'(sym_err_out), 32'd14);
        check("e_bit", 32'(bit_err_out), 32'd14);
        check("e_locked", 32'(locked), 32'd1);
        check("e_resync", 32'(resync_cnt), 32'd2);

        // Clear mid-window: pre-clear errors are discarded
        for (int i = 0; i < 100; i++) begin
            send_tx((i == 10 || i == 20 || i == 30) ? 2'b11 : 2'b00);
        end
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        check_zero("clear");
        tx_s = 22'h3FFFFF;
        relock("clr_relock");
        for (int i = 0; i < 512; i++) begin
            send_tx((i == 100 || i == 300) ? 2'b01 : 2'b00);
        end
        check("g_sym", 32'(sym_err_out), 32'd2);
        check("g_bit", 32'(bit_err_out), 32'd2);

        // Reset low for one cycle mid-window
        for (int i = 0; i < 50; i++) send_tx((i == 5) ? 2'b11 : 2'b00);
        reset = 1'b0;
        #2;
        check_zero("rst_async");
        idle(1);
        reset = 1'b1;
        idle(1);
        check_zero("rst_after");

        // All-zero input holds HUNT; valid data then locks in 54
        seen = 1'b0;
        repeat (100) begin
            send(2'b00);
            if (state != 2'd0) seen = 1'b1;
        end
        check("zero_stays_hunt", 32'(seen), 32'd0);
        check("zero_unlocked", 32'(locked), 32'd0);
        tx_s = 22'h3FFFFF;
        relock("zero_relock");

        // Gray-coded stream into the binary build never locks
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        tx_s = 22'h3FFFFF;
        seen = 1'b0;
        repeat (400) begin
            send({tx_s[1], tx_s[1] ^ tx_s[0]});
            tx_s = lfsr_next(tx_s);
            if (locked) seen = 1'b1;
        end
        check("gray_no_lock", 32'(seen), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prbs_sym_checker.md
Name: prbs_sym_checker

Overview:
- Receive-end partner of the 22-bit LFSR symbol source feeding the 4-ASK mapper.
- Takes the 2-bit slicer decision per symbol and self-synchronises a local replica of the transmit LFSR. Once locked, it counts symbol errors and bit errors over a fixed window.
- Sits after the slicer in the MER circuit on the sys_clk domain. It is strobed by sym_clk_en and gives a BER figure alongside the MER measurement.

Parameters:
- LFSR_LEN, 22: replica width. Must equal the transmit LFSR width.
- TAP_HI, 21: first feedback tap. Next bit = S[TAP_HI] ^ S[TAP_LO].
- TAP_LO, 20: second feedback tap.
- VERIFY_LEN, 32: consecutive error-free symbols needed to declare lock.
- LOSS_BLK, 64: symbol block length used for loss-of-lock detection.
- LOSS_THRESH, 8: symbol errors within one LOSS_BLK block that force a resync.
- WIN_LEN, 65536: symbols per measurement window.
- CNT_W, 18: width of the error counters and result outputs.

Ports:
- sys_clk, input, 1: system clock. Everything is rising-edge.
- reset, input, 1: asynchronous, active-low reset.
- sym_clk_en, input, 1: symbol strobe, one sys_clk cycle wide. The block acts only when it is high.
- clear, input, 1: synchronous restart. Forces HUNT and zeroes all accumulators and results.
- slice, input, 2: slicer decision for the current symbol.
- locked, output, 1: high in LOCK state.
- state, output, 2: 0 = HUNT, 1 = VERIFY, 2 = LOCK.
- sym_err_out, output, CNT_W: symbol-error count of the last completed window.
- bit_err_out, output, CNT_W: bit-error count of the last completed window.
- window_done, output, 1: one-cycle pulse when the two result outputs update.
- resync_cnt, output, 8: number of LOCK-to-HUNT transitions. Saturates at 255.

Behaviour:
- Transmit model:
  - Transmit state S advances once per symbol: S <= {S[LFSR_LEN-2:0], S[TAP_HI]^S[TAP_LO]}.
  - Transmitted symbol = S[1:0].
  - Therefore slice[0] at symbol k equals the transmit LFSR LSB at symbol k.
- Reset (reset low, asynchronous):
  - state = HUNT; replica R = 0; all counters = 0.
  - locked = 0, window_done = 0, sym_err_out = 0, bit_err_out = 0, resync_cnt = 0.
- HUNT:
  - On each strobe, R <= {R[LFSR_LEN-2:0], slice[0]} and a fill counter increments.
  - After LFSR_LEN strobes: if R != 0, go to VERIFY on the next cycle. If R == 0 (lock-up state), restart the fill and stay in HUNT.
- Prediction (VERIFY and LOCK):
  - On each strobe, P = {R[LFSR_LEN-2:0], R[TAP_HI]^R[TAP_LO]}.
  - Compare P[1:0] with slice. Then R <= P. The replica free-runs and is never reloaded from input.
  - sym_err = (P[1:0] != slice).
  - bits wrong = popcount(P[1:0] ^ slice), range 0..2.
- VERIFY:
  - Counts consecutive error-free symbols.
  - Any error: back to HUNT, fill counter cleared. resync_cnt is not incremented.
  - VERIFY_LEN consecutive good symbols: go to LOCK. The window counter and accumulators start at 0.
- LOCK:
  - Each strobe: window counter +1, sym_err accumulator +sym_err, bit_err accumulator +bits wrong. Both accumulators saturate at 2^CNT_W-1.
  - A LOSS_BLK-symbol block counter runs in parallel.
  - If the block error count reaches LOSS_THRESH before the block ends: go to HUNT on the same strobe; resync_cnt +1; partial window discarded; result outputs unchanged.
  - The block error count clears at each block boundary.
- Window end:
  - On the strobe that completes WIN_LEN symbols, the registered outputs take accumulator values that include that strobe's contribution.
  - window_done pulses high on the following cycle, for exactly one cycle.
  - Accumulators restart from 0 with the next symbol. No symbol is lost or double-counted.
- Latency: strobe to state/locked change is one sys_clk cycle. locked is registered and equals (state == LOCK).
- Simultaneous events:
  - clear has priority over everything except reset.
  - If loss-of-lock and window end occur on the same strobe, loss wins: no window_done, outputs held.
- Reset asserted mid-window discards everything. clear behaves the same way, except it is synchronous.
- Strobe gaps of any length are allowed. The block holds state between strobes.

Optional Feature:
- Macro: PRBS_SYM_CHECKER_GRAY_EN.
- Defined: slice is Gray-coded. It is decoded to binary {slice[1], slice[1]^slice[0]} before all use, including HUNT fill and comparison. Bit-error counting is done on the Gray-coded values: popcount(gray(P[1:0]) ^ slice).
- Undefined: slice is used as binary directly.

Test Plan:
- Error-free stream, taps 21/20, seed 22'h3FFFFF, any slicer delay:
  - locked = 1 exactly 22 + 32 strobes after the first strobe.
  - After 65536 more strobes, window_done pulses with sym_err_out = 0 and bit_err_out = 0.
- Locked stream with slice inverted (both bits) on 5 chosen symbols and bit0 flipped on 3 others within one window:
  - sym_err_out = 8, bit_err_out = 13, locked stays 1.
- All-zero slice for 100 strobes from reset:
  - state stays HUNT, locked = 0.
  - Then a valid stream gives lock after 54 more strobes.
- Locked, then 8 errored symbols inside one 64-symbol block:
  - state = HUNT on the 8th error strobe.
  - resync_cnt = 1, no window_done.
  - Re-lock 54 strobes after valid data resumes.
- clear pulse mid-window while locked, and separately reset low for 1 cycle:
  - state = HUNT, all outputs zero.
  - The next window counts only post-clear errors.
- With PRBS_SYM_CHECKER_GRAY_EN and a Gray-coded clean stream: lock and 0 errors. Without the macro, the same stream gives no stable lock (resync or HUNT loops).
